// File: rtl/cam_read_pipe_if.sv
// Request/response bundle for cam_read_pipe. Optional parity_o exists only when
// CAM_READ_PARITY_EN is defined.
interface cam_read_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned SIZE = DEPTH * DATA_WIDTH;

    logic [SIZE-1:0]       all_data_i;
    logic [ADDR_WIDTH-1:0] index_i;
    logic [DEPTH-1:0]      read_valid_i;
    logic                  req_i;
    logic                  req_ready_o;
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  read_valid_o;
    logic                  err_o;
`ifdef CAM_READ_PARITY_EN
    logic                  parity_o;
`endif

    // The read pipe itself.
    modport slave (
        input  all_data_i, index_i, read_valid_i, req_i, resp_ready_i,
        output req_ready_o, resp_valid_o, data_o, read_valid_o, err_o
`ifdef CAM_READ_PARITY_EN
        , output parity_o
`endif
    );

    modport master (
        output all_data_i, index_i, read_valid_i, req_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, data_o, read_valid_o, err_o
`ifdef CAM_READ_PARITY_EN
        , input parity_o
`endif
    );
endinterface

// File: rtl/cam_read_pipe.sv
// Registered CAM read port: entry select + hit reduction into a 2-entry response FIFO.
// Optional per-entry data parity output enabled by CAM_READ_PARITY_EN.
module cam_read_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic            clk,
    input logic            reset,
    cam_read_pipe_if.slave bus
);
    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  hit;
        logic                  err;
`ifdef CAM_READ_PARITY_EN
        logic                  parity;
`endif
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t cap;
    logic   in_range;
    logic   multi_hit;
    logic   accept;
    logic   pop;

    assign in_range  = 32'(bus.index_i) < DEPTH;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_hit = |(bus.read_valid_i & (bus.read_valid_i - {{(DEPTH-1){1'b0}}, 1'b1}));

    always_comb begin
        cap = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (bus.index_i == ADDR_WIDTH'(k)) begin
                cap.data = bus.all_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        cap.hit = in_range && (|bus.read_valid_i);
        cap.err = !in_range || multi_hit;
`ifdef CAM_READ_PARITY_EN
        cap.parity = ^cap.data;
`endif
    end

    assign accept = bus.req_i && (state_q != StFull);
    assign pop    = (state_q != StEmpty) && bus.resp_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    head_d  = cap;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    head_d = cap;
                end else if (accept) begin
                    state_d = StFull;
                    tail_d  = cap;
                end else if (pop) begin
                    state_d = StEmpty;
                    head_d  = '0;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StOne;
                    head_d  = tail_q;
                    tail_d  = '0;
                end
            end
            default: begin
                state_d = StEmpty;
                head_d  = '0;
                tail_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Head is zeroed whenever the buffer drains, so idle outputs read as 0.
    assign bus.req_ready_o  = (state_q != StFull);
    assign bus.resp_valid_o = (state_q != StEmpty);
    assign bus.data_o       = head_q.data;
    assign bus.read_valid_o = head_q.hit;
    assign bus.err_o        = head_q.err;
`ifdef CAM_READ_PARITY_EN
    assign bus.parity_o     = head_q.parity;
`endif
endmodule

// File: tb/tb_cam_read_pipe.sv
// Self-checking bench for cam_read_pipe: directed scenarios plus randomized traffic
// compared against a queue-based response model.
module tb_cam_read_pipe;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 24;
    localparam int unsigned AW    = 5;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          hit;
        logic          err;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] mem [DEPTH];
    resp_t         mq [$];
    int            errors = 0;
    int            checks = 0;

    cam_read_pipe_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

    cam_read_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) bus.all_data_i[k*DW +: DW] = mem[k];
    end

    function automatic resp_t ref_resp(int idx, logic [DEPTH-1:0] rv);
        resp_t r;
        if (idx >= DEPTH) begin
            r.data = '0;
            r.hit  = 1'b0;
            r.err  = 1'b1;
        end else begin
            r.data = mem[idx];
            r.hit  = (rv != '0);
            r.err  = ($countones(rv) > 1);
        end
        return r;
    endfunction

    function automatic resp_t exp_head();
        resp_t r;
        r = '0;
        if (mq.size() > 0) r = mq[0];
        return r;
    endfunction

    // Advance one clock and update the model; outputs are sampled 1 ns after the edge.
    task automatic tick();
        bit    acc;
        bit    pop;
        resp_t r;
        acc = (bus.req_i === 1'b1) && (mq.size() < 2) && !reset;
        pop = (mq.size() > 0) && (bus.resp_ready_i === 1'b1) && !reset;
        r   = ref_resp(int'(bus.index_i), bus.read_valid_i);
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(r);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_i = 1'b1;
        bus.index_i = 5'd2;
        bus.read_valid_i = DEPTH'(4);
        bus.resp_ready_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bus.req_i = 1'b0;
        checks++;
        if ({bus.resp_valid_o, bus.data_o, bus.read_valid_o, bus.err_o, bus.req_ready_o} !==
            {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_idle: got v=%b d=%h rv=%b e=%b rdy=%b, want v=0 d=0 rv=0 e=0 rdy=1",
                     bus.resp_valid_o, bus.data_o, bus.read_valid_o, bus.err_o, bus.req_ready_o);
        end
`ifdef CAM_READ_PARITY_EN
        checks++;
        if (bus.parity_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b want 0", bus.parity_o);
        end
`endif
        tick();
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: got resp_valid=%b want 0", bus.resp_valid_o);
        end
    endtask

    task automatic test_basic();
        mem[5] = 32'hDEADBEEF;
        bus.index_i = 5'd5;
        bus.read_valid_i = DEPTH'(1) << 5;
        bus.resp_ready_i = 1'b1;
        bus.req_i = 1'b1;
        tick();
        bus.req_i = 1'b0;
        checks++;
        if ({bus.resp_valid_o, bus.data_o, bus.read_valid_o, bus.err_o} !==
            {1'b1, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL basic_read: got v=%b d=%h rv=%b e=%b, want v=1 d=deadbeef rv=1 e=0",
                     bus.resp_valid_o, bus.data_o, bus.read_valid_o, bus.err_o);
        end
        tick();
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got resp_valid=%b want 0", bus.resp_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] want [3] = '{32'h11, 32'h22, 32'h33};
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        bus.resp_ready_i = 1'b0;
        bus.read_valid_i = '0;
        bus.req_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.index_i = AW'(i);
            tick();
        end
        bus.index_i = 5'd2;
        tick();
        checks++;
        if ({bus.req_ready_o, bus.resp_valid_o, bus.data_o} !== {1'b0, 1'b1, 32'h11}) begin
            errors++;
            $display("FAIL bp_full_hold: got rdy=%b v=%b d=%h, want rdy=0 v=1 d=11",
                     bus.req_ready_o, bus.resp_valid_o, bus.data_o);
        end
        bus.resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bus.resp_valid_o, bus.data_o} !== {1'b1, want[i]}) begin
                errors++;
                $display("FAIL bp_order[%0d]: got v=%b d=%h, want v=1 d=%h",
                         i, bus.resp_valid_o, bus.data_o, want[i]);
            end
            tick();
            if (i == 0) bus.req_i = 1'b1;
            else bus.req_i = 1'b0;
        end
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got resp_valid=%b want 0", bus.resp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) mem[i+8] = $urandom;
        bus.resp_ready_i = 1'b1;
        bus.req_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.index_i = AW'(i + 8);
            bus.read_valid_i = DEPTH'(1) << (i + 8);
            tick();
            checks++;
            if ({bus.req_ready_o, bus.resp_valid_o, bus.data_o, bus.read_valid_o} !==
                {1'b1, 1'b1, mem[i+8], 1'b1}) begin
                errors++;
                $display("FAIL b2b[%0d]: got rdy=%b v=%b d=%h rv=%b, want rdy=1 v=1 d=%h rv=1",
                         i, bus.req_ready_o, bus.resp_valid_o, bus.data_o, bus.read_valid_o,
                         mem[i+8]);
            end
        end
        bus.req_i = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        int            idx [3] = '{1, 30, 4};
        logic [23:0]   rvv [3] = '{24'h3, 24'h10, 24'h0};
        logic [33:0]   want [3];
        mem[1] = 32'hA5A5_0001;
        mem[4] = 32'h0BAD_F00D;
        want[0] = {32'hA5A5_0001, 1'b1, 1'b1};
        want[1] = {32'h0, 1'b0, 1'b1};
        want[2] = {32'h0BAD_F00D, 1'b0, 1'b0};
        bus.resp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.index_i = AW'(idx[i]);
            bus.read_valid_i = rvv[i];
            bus.req_i = 1'b1;
            tick();
            bus.req_i = 1'b0;
            checks++;
            if ({bus.data_o, bus.read_valid_o, bus.err_o} !== want[i]) begin
                errors++;
                $display("FAIL err_case[%0d]: got d=%h rv=%b e=%b, want {d,rv,e}=%h",
                         i, bus.data_o, bus.read_valid_o, bus.err_o, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        mem[3] = 32'h0000_0007;
        bus.resp_ready_i = 1'b0;
        bus.index_i = 5'd3;
        bus.read_valid_i = DEPTH'(8);
        bus.req_i = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.req_ready_o, bus.resp_valid_o, bus.data_o} !== {1'b0, 1'b1, 32'h7}) begin
            errors++;
            $display("FAIL mid_full: got rdy=%b v=%b d=%h, want rdy=0 v=1 d=7",
                     bus.req_ready_o, bus.resp_valid_o, bus.data_o);
        end
`ifdef CAM_READ_PARITY_EN
        checks++;
        if (bus.parity_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_parity: got %b want 1", bus.parity_o);
        end
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_i = 1'b0;
        checks++;
        if ({bus.resp_valid_o, bus.req_ready_o, bus.data_o, bus.err_o, bus.read_valid_o} !==
            {1'b0, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got v=%b rdy=%b d=%h e=%b rv=%b, want v=0 rdy=1 d=0 e=0 rv=0",
                     bus.resp_valid_o, bus.req_ready_o, bus.data_o, bus.err_o, bus.read_valid_o);
        end
    endtask

    task automatic test_random();
        resp_t e;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) mem[$urandom_range(0, DEPTH-1)] = $urandom;
            bus.req_i = ($urandom_range(0, 3) != 0);
            bus.resp_ready_i = ($urandom_range(0, 2) != 0);
            bus.index_i = AW'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: bus.read_valid_i = '0;
                1: bus.read_valid_i = DEPTH'(1) << $urandom_range(0, DEPTH-1);
                default: bus.read_valid_i = DEPTH'($urandom);
            endcase
            e = exp_head();
            checks++;
            if ({bus.req_ready_o, bus.resp_valid_o, bus.data_o, bus.read_valid_o, bus.err_o} !==
                {mq.size() < 2, mq.size() > 0, e.data, e.hit, e.err}) begin
                errors++;
                $display("FAIL rand[%0d]: got rdy=%b v=%b d=%h rv=%b e=%b, want rdy=%b v=%b d=%h rv=%b e=%b",
                         n, bus.req_ready_o, bus.resp_valid_o, bus.data_o, bus.read_valid_o,
                         bus.err_o, mq.size() < 2, mq.size() > 0, e.data, e.hit, e.err);
            end
`ifdef CAM_READ_PARITY_EN
            checks++;
            if (bus.parity_o !== ^e.data) begin
                errors++;
                $display("FAIL rand_parity[%0d]: got %b want %b", n, bus.parity_o, ^e.data);
            end
`endif
            tick();
        end
        bus.req_i = 1'b0;
        bus.resp_ready_i = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: got resp_valid=%b want 0", bus.resp_valid_o);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        bus.req_i = 1'b0;
        bus.resp_ready_i = 1'b0;
        bus.index_i = '0;
        bus.read_valid_i = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
